// File: rtl/z80_pins_pkg.sv
// Shared types and parameter limits for the Z80 external-bus pin interface.
package z80_pins_pkg;

  typedef enum logic [1:0] {
    BUS_RUN     = 2'd0,
    BUS_GRANT   = 2'd1,
    BUS_RELEASE = 2'd2
  } busState_e;

  localparam int SYNC_MIN  = 1;
  localparam int SYNC_MAX  = 4;
  localparam int WAITS_MIN = 0;
  localparam int WAITS_MAX = 7;
  localparam int WAIT_CW   = 3;

endpackage

// File: rtl/z80_pin_sync.sv
// Single-bit input-pin synchroniser; resets to the inactive (high) pin level.
module z80_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic pin,
  output logic pinSync
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) pipe <= '1;
    else         pipe <= (pipe << 1) | STAGES'(pin);
  end

  assign pinSync = pipe[STAGES-1];

endmodule

// File: rtl/z80_pin_interface_p.sv
// External-bus pin interface for the A-Z80 core: registered pins, input
// synchronisers, automatic I/O waits, NMI edge latch and bus request/grant.
module z80_pin_interface_p
  import z80_pins_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IO_WAITS    = 1
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic [AW-1:0] address,
  input  logic          bus_ab_pin_we,
  input  logic [DW-1:0] bus_db_oe,
  input  logic          bus_db_pin_oe,
  input  logic          bus_db_pin_re,
  output logic [DW-1:0] db_in,
  input  logic          cyc_m1,
  input  logic          cyc_mreq,
  input  logic          cyc_iorq,
  input  logic          cyc_rd,
  input  logic          cyc_wr,
  input  logic          cyc_rfsh,
  input  logic          in_halt,
  input  logic          cyc_end,
  input  logic          nmi_ack,
  output wire logic [AW-1:0] A,
  inout  wire logic [DW-1:0] D,
  output wire logic     nM1,
  output wire logic     nMREQ,
  output wire logic     nIORQ,
  output wire logic     nRD,
  output wire logic     nWR,
  output wire logic     nRFSH,
  output logic          nHALT,
  output logic          nBUSACK,
  input  logic          nWAIT,
  input  logic          nINT,
  input  logic          nNMI,
  input  logic          nBUSRQ,
  output logic          mwait,
  output logic          intr,
  output logic          nmi,
  output logic          busrq_pending,
  output logic          busack
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : gBadSync
    $error("SYNC_STAGES out of range");
  end
  if (IO_WAITS < WAITS_MIN || IO_WAITS > WAITS_MAX) begin : gBadWaits
    $error("IO_WAITS out of range");
  end

  // Pin order: [0] nWAIT, [1] nINT, [2] nNMI, [3] nBUSRQ
  logic [3:0] pinsRaw, pinsSync;
  assign pinsRaw = {nBUSRQ, nNMI, nINT, nWAIT};

  z80_pin_sync #(.STAGES(SYNC_STAGES)) uSync [3:0] (
    .CLK    (CLK),
    .nRESET (nRESET),
    .pin    (pinsRaw),
    .pinSync(pinsSync)
  );

  logic waitSync, intSync, nmiSync, busrqSync;
  assign {busrqSync, nmiSync, intSync, waitSync} = pinsSync;

  busState_e          state, stateNext;
  logic [AW-1:0]      aReg;
  logic [DW-1:0]      dReg;
  logic [5:0]         ctrlReg;
  logic               haltReg, busackReg, nmiPrev, iorqPrev;
  logic [WAIT_CW-1:0] waitCnt;
  logic               iorqRise, nmiFall, pinsDrive;

  assign iorqRise  = cyc_iorq & ~iorqPrev;
  assign nmiFall   = nmiPrev & ~nmiSync;
  assign pinsDrive = (state == BUS_RUN);

  always_comb begin
    stateNext     = state;
    busrq_pending = 1'b0;
    unique case (state)
      BUS_RUN: begin
        busrq_pending = ~busrqSync;
        if (cyc_end && !busrqSync) stateNext = BUS_GRANT;
      end
      BUS_GRANT:   if (busrqSync) stateNext = BUS_RELEASE;
      BUS_RELEASE: stateNext = BUS_RUN;
      default:     stateNext = BUS_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= BUS_RUN;
      aReg      <= '0;
      dReg      <= '0;
      db_in     <= '0;
      ctrlReg   <= '1;
      haltReg   <= 1'b1;
      busackReg <= 1'b0;
      nmiPrev   <= 1'b1;
      iorqPrev  <= 1'b0;
      waitCnt   <= '0;
      nmi       <= 1'b0;
    end else begin
      state     <= stateNext;
      if (bus_ab_pin_we) aReg  <= address;
      if (bus_db_pin_oe) dReg  <= bus_db_oe;
      if (bus_db_pin_re) db_in <= D;
      ctrlReg   <= ~{cyc_rfsh, cyc_wr, cyc_rd, cyc_iorq, cyc_mreq, cyc_m1};
      haltReg   <= ~in_halt;
      // Registered off the next state so busack is valid in the first GRANT cycle
      busackReg <= (stateNext == BUS_GRANT);
      iorqPrev  <= cyc_iorq;
      nmiPrev   <= nmiSync;
      if (iorqRise)            waitCnt <= WAIT_CW'(IO_WAITS);
      else if (waitCnt != '0)  waitCnt <= waitCnt - WAIT_CW'(1);
      // A fresh edge wins over a simultaneous acknowledge
      if (nmiFall)      nmi <= 1'b1;
      else if (nmi_ack) nmi <= 1'b0;
    end
  end

  assign A     = pinsDrive ? aReg : 'z;
  assign D     = (pinsDrive && bus_db_pin_oe) ? dReg : 'z;
  assign nM1   = pinsDrive ? ctrlReg[0] : 1'bz;
  assign nMREQ = pinsDrive ? ctrlReg[1] : 1'bz;
  assign nIORQ = pinsDrive ? ctrlReg[2] : 1'bz;
  assign nRD   = pinsDrive ? ctrlReg[3] : 1'bz;
  assign nWR   = pinsDrive ? ctrlReg[4] : 1'bz;
  assign nRFSH = pinsDrive ? ctrlReg[5] : 1'bz;

  assign nHALT   = haltReg;
  assign busack  = busackReg;
  assign nBUSACK = ~busackReg;
  assign mwait   = ~waitSync | (waitCnt != '0);
  assign intr    = ~intSync;

endmodule
